// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for a single-cycle core.
// Serves a word RAM, a free-running cycle counter, an output FIFO with a
// valid/ready drain port and a sticky status register.
module dmem_responder #(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [29:0] CNT_WORD  = MMIO_BASE[31:2];
  localparam logic [29:0] FIFO_WORD = MMIO_BASE[31:2] + 30'd1;
  localparam logic [29:0] STAT_WORD = MMIO_BASE[31:2] + 30'd2;

  // Storage: RAM and FIFO payload carry no reset, only control state does.
  logic [31:0]   mem      [RAM_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   cycle_cnt;
  logic          ovf;
  logic          bad;

  // Address decode; the RAM window wins if MMIO_BASE is ever placed inside it.
  logic [29:0]   word_idx;
  logic [AW-1:0] ram_idx;
  logic          sel_ram, sel_cnt, sel_fifo, sel_stat, sel_unmapped;

  assign word_idx     = dmem_addr[31:2];
  assign ram_idx      = dmem_addr[AW+1:2];
  assign sel_ram      = (dmem_addr < RAM_BYTES);
  assign sel_cnt      = !sel_ram && (word_idx == CNT_WORD);
  assign sel_fifo     = !sel_ram && (word_idx == FIFO_WORD);
  assign sel_stat     = !sel_ram && (word_idx == STAT_WORD);
  assign sel_unmapped = !(sel_ram || sel_cnt || sel_fifo || sel_stat);

  // FIFO handshake: a pop on a full FIFO frees the slot the push needs.
  logic full, empty, pop, push_req, push_ok, ovf_set, ovf_clr, bad_set, bad_clr;
  logic stat_wr;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop      = out_valid && out_ready;
  assign push_req = dmem_we && sel_fifo;
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign stat_wr  = dmem_we && sel_stat;
  assign ovf_clr  = stat_wr && dmem_wdata[8];
  assign bad_clr  = stat_wr && dmem_wdata[9];
  assign bad_set  = dmem_we && sel_unmapped;

  assign out_valid = !empty;
  assign out_data  = empty ? 32'h0 : fifo_mem[rd_ptr];

  logic [31:0] stat_word;
  assign stat_word = (32'(count) << 2) | {22'd0, bad, ovf, 6'd0, empty, full};

  // Load path: purely combinational so the core sees data in the same cycle.
  always_comb begin
    dmem_rdata = 32'h0;
    if (sel_ram)       dmem_rdata = mem[ram_idx];
    else if (sel_cnt)  dmem_rdata = cycle_cnt;
    else if (sel_stat) dmem_rdata = stat_word;
  end

  // RAM store; a store issued during reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst && dmem_we && sel_ram) mem[ram_idx] <= dmem_wdata;
  end

  // FIFO payload write at the tail.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) fifo_mem[wr_ptr] <= dmem_wdata;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Cycle counter: a store loads it and suppresses that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst)                  cycle_cnt <= 32'h0;
    else if (dmem_we && sel_cnt) cycle_cnt <= dmem_wdata;
    else                      cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Sticky error flags; a write-one clear beats a simultaneous set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      bad <= 1'b0;
    end else begin
      ovf <= (ovf || ovf_set) && !ovf_clr;
      bad <= (bad || bad_set) && !bad_clr;
    end
  end

endmodule
